tinyalu_core: RTL and testbench

//  Responder side of the TinyALU start/done command protocol: the synthesizable ALU the BFM drives.

---
 rtl/tinyalu_pkg.sv | 63 ++++++
 rtl/tinyalu_mult_pipe.sv | 51 +++++
 rtl/tinyalu_core.sv | 150 +++++++++++++++
 tb/tb_tinyalu_core.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinyalu_pkg.sv
// -----------------------------------------------------------------------------
// tinyalu_pkg
// Shared definitions for the TinyALU responder.
//   operation_t      command encoding on the 'op' bus. rst_op is used by the
//                    testbench to request a reset; the core never decodes it
//                    and treats 3'b111 as an illegal op.
//   tinyalu_state_t  FSM state type of tinyalu_core.
//   RESULT_W         width of the result bus.
// Helper functions classify op codes and compute the single-cycle results.
// -----------------------------------------------------------------------------
package tinyalu_pkg;

    localparam int OPERAND_W = 8;
    localparam int RESULT_W  = 16;

    typedef enum logic [2:0] {
        no_op  = 3'b000,
        add_op = 3'b001,
        and_op = 3'b010,
        xor_op = 3'b011,
        mul_op = 3'b100,
        rst_op = 3'b111
    } operation_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SINGLE   = 2'd1,
        MUL      = 2'd2,
        WAIT_LOW = 2'd3
    } tinyalu_state_t;

    // add/and/xor complete one edge after they are accepted
    function automatic logic is_single_op(input logic [2:0] code);
        return (code == 3'b001) || (code == 3'b010) || (code == 3'b011);
    endfunction

    function automatic logic is_mul_op(input logic [2:0] code);
        return (code == 3'b100);
    endfunction

    // codes 101..111 have no operation assigned
    function automatic logic is_illegal_op(input logic [2:0] code);
        return code[2] && (code[1:0] != 2'b00);
    endfunction

    // add keeps its carry in bit 8; logic ops are zero-extended
    function automatic logic [RESULT_W-1:0] single_result(
        input logic [2:0]           code,
        input logic [OPERAND_W-1:0] a,
        input logic [OPERAND_W-1:0] b
    );
        logic [RESULT_W-1:0] r;
        r = '0;
        case (code)
            3'b001:  r = {7'b0, ({1'b0, a} + {1'b0, b})};
            3'b010:  r = {8'b0, (a & b)};
            3'b011:  r = {8'b0, (a ^ b)};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tinyalu_mult_pipe.sv
// -----------------------------------------------------------------------------
// tinyalu_mult_pipe
// STAGES-deep registered unsigned 8x8 multiplier with a travelling valid bit.
// The product is formed into stage 0 on the edge valid_in is sampled and
// shifted one stage per edge; valid_out is high while the last stage holds a
// product that entered with valid_in=1. Reset flushes every stage.
// Ports:
//   clk        in   1   clock, posedge
//   reset      in   1   asynchronous, active-high flush
//   valid_in   in   1   operands a/b are to be multiplied this edge
//   a, b       in   8   unsigned operands
//   valid_out  out  1   product on 'product' is valid
//   product    out  16  last-stage product
// -----------------------------------------------------------------------------
module tinyalu_mult_pipe
    import tinyalu_pkg::*;
#(
    parameter int STAGES = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_in,
    input  logic [OPERAND_W-1:0] a,
    input  logic [OPERAND_W-1:0] b,
    output logic                 valid_out,
    output logic [RESULT_W-1:0]  product
);

    logic [RESULT_W-1:0] prod_q [STAGES];
    logic [STAGES-1:0]   vld_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            vld_q[0]  <= valid_in;
            prod_q[0] <= {8'b0, a} * {8'b0, b};
            for (int i = 1; i < STAGES; i++) begin
                vld_q[i]  <= vld_q[i-1];
                prod_q[i] <= prod_q[i-1];
            end
        end
    end

    assign valid_out = vld_q[STAGES-1];
    assign product   = prod_q[STAGES-1];

endmodule

// File: rtl/tinyalu_core.sv
// -----------------------------------------------------------------------------
// tinyalu_core
// Responder side of the TinyALU start/done command protocol.
//
// Handshake: the requester raises start with A/B/op stable and holds it until
// it sees done. The core accepts on the first IDLE edge with start=1 and a
// real op, answers with a single-cycle registered done pulse and the value on
// result, then ignores start until it has been seen low, so a late drop never
// re-executes. Dropping start before done does not abort the operation.
//
// Optional feature: define TINYALU_ERR_EN to add the 'err' output, which
// pulses once per start assertion that carries an illegal op (101..111).
//
// Ports:
//   clk     in   1   clock, posedge
//   reset   in   1   asynchronous, active-high
//   A, B    in   8   unsigned operands
//   op      in   3   operation code (see operation_t)
//   start   in   1   request
//   done    out  1   one-cycle pulse, result valid
//   result  out  16  last completed answer
//   err     out  1   (TINYALU_ERR_EN only) illegal-op pulse
//   state   out  2   current FSM state, for observation
// -----------------------------------------------------------------------------
module tinyalu_core
    import tinyalu_pkg::*;
#(
    parameter int MUL_LATENCY = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [OPERAND_W-1:0] A,
    input  logic [OPERAND_W-1:0] B,
    input  logic [2:0]           op,
    input  logic                 start,
    output logic                 done,
    output logic [RESULT_W-1:0]  result,
`ifdef TINYALU_ERR_EN
    output logic                 err,
`endif
    output tinyalu_state_t       state
);

    tinyalu_state_t       state_q, state_d;
    logic                 accept_single, accept_mul;
    logic                 done_d;
    logic [RESULT_W-1:0]  result_d;
    logic [OPERAND_W-1:0] a_q, b_q;
    logic [2:0]           op_q;
    logic                 mul_valid;
    logic [RESULT_W-1:0]  mul_product;

    // The pipe captures A/B on the accept edge; its last stage is valid one
    // edge before done, so the result register completes MUL_LATENCY edges.
    tinyalu_mult_pipe #(
        .STAGES (MUL_LATENCY)
    ) u_mult_pipe (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (accept_mul),
        .a         (A),
        .b         (B),
        .valid_out (mul_valid),
        .product   (mul_product)
    );

    always_comb begin
        state_d       = state_q;
        done_d        = 1'b0;
        result_d      = result;
        accept_single = 1'b0;
        accept_mul    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (is_single_op(op)) begin
                        accept_single = 1'b1;
                        state_d       = SINGLE;
                    end else if (is_mul_op(op)) begin
                        accept_mul = 1'b1;
                        state_d    = MUL;
                    end
                end
            end
            SINGLE: begin
                done_d   = 1'b1;
                result_d = single_result(op_q, a_q, b_q);
                // requester already gone: no need to wait for start low
                state_d  = start ? WAIT_LOW : IDLE;
            end
            MUL: begin
                if (mul_valid) begin
                    done_d   = 1'b1;
                    result_d = mul_product;
                    state_d  = start ? WAIT_LOW : IDLE;
                end
            end
            WAIT_LOW: begin
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            done    <= 1'b0;
            result  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            done    <= done_d;
            result  <= result_d;
            if (accept_single) begin
                a_q  <= A;
                b_q  <= B;
                op_q <= op;
            end
        end
    end

    assign state = state_q;

`ifdef TINYALU_ERR_EN
    // armed until an illegal request is flagged; re-armed once start is low
    logic err_armed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err       <= 1'b0;
            err_armed <= 1'b1;
        end else begin
            err <= 1'b0;
            if (!start) begin
                err_armed <= 1'b1;
            end
            if ((state_q == IDLE) && start && is_illegal_op(op) && err_armed) begin
                err       <= 1'b1;
                err_armed <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tinyalu_core.sv
// -----------------------------------------------------------------------------
// tb_tinyalu_core
// Self-checking bench for tinyalu_core. A reference model computes answers and
// latencies from the op table with plain arithmetic; expected results are
// queued when a command is issued and popped when done is observed.
// Define TINYALU_ERR_EN to also exercise the err output.
// -----------------------------------------------------------------------------
module tb_tinyalu_core;
    import tinyalu_pkg::*;

    localparam int MUL_LAT   = 3;
    localparam int OP_BUDGET = 12;

    logic           clk;
    logic           reset;
    logic [7:0]     A, B;
    logic [2:0]     op;
    logic           start;
    logic           done;
    logic [15:0]    result;
    tinyalu_state_t state;
`ifdef TINYALU_ERR_EN
    logic           err;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_q[$];
    logic [15:0] model_result = 16'h0000;

    tinyalu_core #(
        .MUL_LATENCY (MUL_LAT)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .A      (A),
        .B      (B),
        .op     (op),
        .start  (start),
        .done   (done),
        .result (result),
`ifdef TINYALU_ERR_EN
        .err    (err),
`endif
        .state  (state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [15:0] ref_result(input logic [2:0] o, input int a, input int b,
                                               input logic [15:0] prev);
        case (o)
            3'd1:    return 16'(a + b);
            3'd2:    return 16'(a & b);
            3'd3:    return 16'(a ^ b);
            3'd4:    return 16'(a * b);
            default: return prev;
        endcase
    endfunction

    // edges from accept to done; 0 means the command never completes
    function automatic int ref_latency(input logic [2:0] o);
        case (o)
            3'd1, 3'd2, 3'd3: return 1;
            3'd4:             return MUL_LAT;
            default:          return 0;
        endcase
    endfunction

    // ---------------- driver ----------------
    // Issues one command from IDLE, holds start for 'hold' edges after done,
    // then drops start and idles two edges. Edge 0 is the accept edge.
    task automatic do_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                         input int hold, output int lat, output logic [15:0] res,
                         output int pulses, output int stray);
        logic [15:0] prev;
        A = a; B = b; op = o; start = 1'b1;
        lat = -1; pulses = 0; stray = 0;
        prev = result;
        for (int k = 0; k < OP_BUDGET; k++) begin
            tick();
            if (done) begin
                pulses++;
                if (lat < 0) lat = k;
            end else if (result !== prev) begin
                stray++;
            end
            prev = result;
            if (lat >= 0 && k >= lat + hold) break;
        end
        res = result;
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            if (done) pulses++;
            if (result !== prev) stray++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int lat, pulses, stray;
        logic [15:0] res;
        reset = 1'b1; start = 1'b0; A = '0; B = '0; op = '0;
        tick(); tick();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (result !== 16'h0000) begin n_bad++; $display("FAIL reset_result: got %h want 0000", result); end
        n_cmp++; if (state !== IDLE) begin n_bad++; $display("FAIL reset_state: got %0d want IDLE", state); end
        reset = 1'b0;
        tick();
        do_op(3'd1, 8'd5, 8'd6, 0, lat, res, pulses, stray);
        model_result = 16'd11;
        n_cmp++; if (res !== 16'd11) begin n_bad++; $display("FAIL pre_reset_add: got %h want 000b", res); end
        // asynchronous reset in the middle of a low clock phase
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (result !== 16'h0000) begin n_bad++; $display("FAIL async_reset_result: got %h want 0000", result); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL async_reset_done: got %b want 0", done); end
        model_result = 16'h0000;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_add_carry();
        int lat, pulses, stray;
        logic [15:0] res;
        do_op(3'd1, 8'hFF, 8'h01, 0, lat, res, pulses, stray);
        model_result = 16'h0100;
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL add_latency: got %0d want 1", lat); end
        n_cmp++; if (res !== 16'h0100) begin n_bad++; $display("FAIL add_result: got %h want 0100", res); end
        n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL add_done_width: got %0d cycles want 1", pulses); end
    endtask

    task automatic test_and_xor();
        int lat, pulses, stray;
        logic [15:0] res;
        do_op(3'd2, 8'hF0, 8'h3C, 0, lat, res, pulses, stray);
        n_cmp++; if (res !== 16'h0030) begin n_bad++; $display("FAIL and_result: got %h want 0030", res); end
        do_op(3'd3, 8'hF0, 8'h3C, 0, lat, res, pulses, stray);
        model_result = 16'h00CC;
        n_cmp++; if (res !== 16'h00CC) begin n_bad++; $display("FAIL xor_result: got %h want 00cc", res); end
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL xor_latency: got %0d want 1", lat); end
    endtask

    task automatic test_mul();
        int lat, pulses, stray;
        logic [15:0] res;
        do_op(3'd4, 8'hFF, 8'hFF, 0, lat, res, pulses, stray);
        model_result = 16'hFE01;
        n_cmp++; if (lat !== MUL_LAT) begin n_bad++; $display("FAIL mul_latency: got %0d want %0d", lat, MUL_LAT); end
        n_cmp++; if (res !== 16'hFE01) begin n_bad++; $display("FAIL mul_result: got %h want fe01", res); end
        n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL mul_pulses: got %0d want 1", pulses); end
        n_cmp++; if (stray !== 0) begin n_bad++; $display("FAIL mul_stray_result_change: got %0d want 0", stray); end
    endtask

    task automatic test_hold_start();
        int lat, pulses, stray;
        logic [15:0] res;
        do_op(3'd1, 8'd2, 8'd3, 4, lat, res, pulses, stray);
        model_result = 16'h0005;
        n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL hold_pulses: got %0d want 1", pulses); end
        n_cmp++; if (res !== 16'h0005) begin n_bad++; $display("FAIL hold_result: got %h want 0005", res); end
    endtask

    task automatic test_start_drop();
        int lat;
        A = 8'd7; B = 8'd9; op = 3'd4; start = 1'b1;
        tick();             // accept edge
        start = 1'b0;
        lat = -1;
        for (int k = 1; k < OP_BUDGET; k++) begin
            tick();
            if (done) begin lat = k; break; end
        end
        model_result = 16'd63;
        n_cmp++; if (lat !== MUL_LAT) begin n_bad++; $display("FAIL drop_latency: got %0d want %0d", lat, MUL_LAT); end
        n_cmp++; if (result !== 16'd63) begin n_bad++; $display("FAIL drop_result: got %h want 003f", result); end
        n_cmp++; if (state !== IDLE) begin n_bad++; $display("FAIL drop_state: got %0d want IDLE", state); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL drop_done_clear: got %b want 0", done); end
    endtask

    task automatic test_mul_reset();
        int lat, pulses, stray, seen;
        logic [15:0] res;
        seen = 0;
        A = 8'd10; B = 8'd10; op = 3'd4; start = 1'b1;
        tick();             // accept edge
        tick();             // edge 1
        if (done) seen++;
        #2;
        reset = 1'b1;
        tick();             // edge 2 under reset
        if (done) seen++;
        reset = 1'b0; start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (done) seen++;
        end
        model_result = 16'h0000;
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL mulrst_done: got %0d pulses want 0", seen); end
        n_cmp++; if (result !== 16'h0000) begin n_bad++; $display("FAIL mulrst_result: got %h want 0000", result); end
        do_op(3'd1, 8'd1, 8'd1, 0, lat, res, pulses, stray);
        model_result = 16'h0002;
        n_cmp++; if (res !== 16'h0002) begin n_bad++; $display("FAIL mulrst_next_add: got %h want 0002", res); end
    endtask

    task automatic test_noop_illegal();
        int lat, pulses, stray;
        logic [15:0] res;
        do_op(3'd0, 8'd9, 8'd9, 0, lat, res, pulses, stray);
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL noop_done: got %0d pulses want 0", pulses); end
        n_cmp++; if (res !== model_result) begin n_bad++; $display("FAIL noop_result: got %h want %h", res, model_result); end
        do_op(3'd5, 8'd9, 8'd9, 0, lat, res, pulses, stray);
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL illegal_done: got %0d pulses want 0", pulses); end
        n_cmp++; if (res !== model_result) begin n_bad++; $display("FAIL illegal_result: got %h want %h", res, model_result); end
    endtask

`ifdef TINYALU_ERR_EN
    task automatic test_err();
        int errs, dones;
        errs = 0; dones = 0;
        A = 8'd1; B = 8'd1; op = 3'b111; start = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (err) errs++;
            if (done) dones++;
        end
        n_cmp++; if (errs !== 1) begin n_bad++; $display("FAIL err_pulses: got %0d want 1", errs); end
        n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL err_done: got %0d want 0", dones); end
        n_cmp++; if (result !== model_result) begin n_bad++; $display("FAIL err_result: got %h want %h", result, model_result); end
        start = 1'b0;
        tick();
        if (err) errs++;
        start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (err) errs++;
        end
        start = 1'b0;
        tick(); tick();
        n_cmp++; if (errs !== 2) begin n_bad++; $display("FAIL err_rearm: got %0d pulses want 2", errs); end
    endtask
`endif

    task automatic test_random();
        int lat, pulses, stray, want_lat, hold;
        logic [15:0] res, want;
        logic [2:0] o;
        logic [7:0] a, b;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            a = 8'($urandom);
            b = 8'($urandom);
            hold = $urandom_range(0, 3);
            want_lat = ref_latency(o);
            if (want_lat > 0) exp_q.push_back(ref_result(o, a, b, model_result));
            do_op(o, a, b, hold, lat, res, pulses, stray);
            if (want_lat > 0) begin
                want = exp_q.pop_front();
                model_result = want;
                n_cmp++; if (res !== want) begin n_bad++; $display("FAIL rand_result[%0d] op=%0d a=%h b=%h: got %h want %h", i, o, a, b, res, want); end
                n_cmp++; if (lat !== want_lat) begin n_bad++; $display("FAIL rand_latency[%0d] op=%0d: got %0d want %0d", i, o, lat, want_lat); end
                n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL rand_pulses[%0d]: got %0d want 1", i, pulses); end
            end else begin
                n_cmp++; if (res !== model_result) begin n_bad++; $display("FAIL rand_noop_result[%0d] op=%0d: got %h want %h", i, o, res, model_result); end
                n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL rand_noop_done[%0d] op=%0d: got %0d want 0", i, o, pulses); end
            end
            n_cmp++; if (stray !== 0) begin n_bad++; $display("FAIL rand_stray[%0d]: got %0d want 0", i, stray); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_add_carry();
        test_and_xor();
        test_mul();
        test_hold_start();
        test_start_drop();
        test_mul_reset();
        test_noop_illegal();
`ifdef TINYALU_ERR_EN
        test_err();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
